bcd_display_driver: RTL and testbench

Sequential, parametrised binary-to-seven-segment display driver. Converts a WIDTH-bit binary value into DIGITS decimal digits using an iterative shift-add-3 (double-dabble) engine with a start/done handshake. Adds optional signed display, leading-zero blanking, overflow indication and selectable segment polarity. Sits between the datapath result register and the board's seven-segment displays.

---
 rtl/bcd_display_driver_pkg.sv | 43 ++++
 rtl/bcd_display_driver_if.sv | 15 +
 rtl/bcd_display_driver_seg7_encode.sv | 25 ++
 rtl/bcd_display_driver.sv | 134 +++++++++++++
 tb/tb_bcd_display_driver.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/bcd_display_driver_pkg.sv
// Shared definitions for the BCD seven-segment display driver.
// Segment patterns are active-high, bit 0 = segment a ... bit 6 = segment g.
package bcd_display_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_FORMAT  = 2'd2
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_MINUS = 7'b1000000;

  // Digits at or above this value get +3 before each double-dabble shift.
  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

  function automatic logic [6:0] digit_pattern(input logic [3:0] digit);
    case (digit)
      4'd0:    digit_pattern = SEG_0;
      4'd1:    digit_pattern = SEG_1;
      4'd2:    digit_pattern = SEG_2;
      4'd3:    digit_pattern = SEG_3;
      4'd4:    digit_pattern = SEG_4;
      4'd5:    digit_pattern = SEG_5;
      4'd6:    digit_pattern = SEG_6;
      4'd7:    digit_pattern = SEG_7;
      4'd8:    digit_pattern = SEG_8;
      4'd9:    digit_pattern = SEG_9;
      default: digit_pattern = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/bcd_display_driver_if.sv
// Start/done handshake plus result bus between a requester and the display driver.
interface bcd_display_driver_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 4
);
  logic              start;
  logic [WIDTH-1:0]  value;
  logic              busy;
  logic              done;
  logic              overflow;
  logic [7*DIGITS-1:0] seg;

  modport master (output start, value, input busy, done, overflow, seg);
  modport slave  (input start, value, output busy, done, overflow, seg);
endinterface

// File: rtl/bcd_display_driver_seg7_encode.sv
// Combinational digit-to-segment encoder with blank/minus overrides and output polarity.
module seg7_encode
  import bcd_display_driver_pkg::*;
#(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic [3:0] digit,
  input  logic       blank,
  input  logic       minus,
  output logic [6:0] seg
);
  logic [6:0] pattern;

  // Minus wins over blank so an overflowed display is dashes everywhere.
  always_comb begin
    if (minus)
      pattern = SEG_MINUS;
    else if (blank)
      pattern = SEG_BLANK;
    else
      pattern = digit_pattern(digit);
  end

  assign seg = ACTIVE_LOW ? ~pattern : pattern;
endmodule

// File: rtl/bcd_display_driver.sv
// Iterative double-dabble binary-to-BCD converter driving DIGITS seven-segment digits,
// with optional sign digit, leading-zero blanking and overflow dashes.
module bcd_display_driver
  import bcd_display_driver_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int DIGITS     = 4,
  parameter bit SIGNED     = 1'b0,
  parameter bit BLANK_LZ   = 1'b1,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clock,
  input  logic reset_n,
  bcd_display_driver_if.slave bus
);
  localparam int MAG_DIGITS = SIGNED ? DIGITS - 1 : DIGITS;
  localparam int BCD_DIGITS = (MAG_DIGITS > 0) ? MAG_DIGITS : 1;
  localparam int BCD_W      = 4 * BCD_DIGITS;
  localparam int CNT_W      = $clog2(WIDTH + 1);
  localparam logic [7*DIGITS-1:0] SEG_OFF = ACTIVE_LOW ? '1 : '0;

  state_t               state_reg, state_next;
  logic [WIDTH-1:0]     bin_reg;
  logic [BCD_W-1:0]     bcd_reg, bcd_adj;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 neg_reg, ovf_acc_reg, overflow_reg, done_reg;
  logic [7*DIGITS-1:0]  seg_reg, seg_next;
  logic                 accept, shift_en, format_en, busy_int;
  logic                 value_neg, ovf_final;
  logic [WIDTH:0]       value_mag;

  // WIDTH+1 bits so the most negative operand has a representable magnitude.
  assign value_neg = SIGNED && bus.value[WIDTH-1];
  assign value_mag = value_neg ? (~{1'b1, bus.value} + {{WIDTH{1'b0}}, 1'b1})
                               : {1'b0, bus.value};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      state_reg <= ST_IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:    if (bus.start) state_next = ST_CONVERT;
      ST_CONVERT: if (cnt_reg == CNT_W'(WIDTH - 1)) state_next = ST_FORMAT;
      ST_FORMAT:  state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_int  = (state_reg != ST_IDLE);
    accept    = (state_reg == ST_IDLE) && bus.start;
    shift_en  = (state_reg == ST_CONVERT);
    format_en = (state_reg == ST_FORMAT);
  end

  genvar gi;
  generate
    for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_add3
      assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= ADD3_THRESHOLD)
                                  ? bcd_reg[4*gi +: 4] + 4'd3
                                  : bcd_reg[4*gi +: 4];
    end
  endgenerate

  // With no magnitude digits available (one signed digit) nothing can ever fit.
  assign ovf_final = ovf_acc_reg || (MAG_DIGITS == 0);

  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      logic [3:0] digit;
      logic       blank, minus;
      if (gi < MAG_DIGITS) begin : g_mag
        logic nonzero_at_or_above;
        assign nonzero_at_or_above = |(bcd_reg >> (4 * gi));
        assign digit = bcd_reg[4*gi +: 4];
        assign blank = BLANK_LZ && (gi != 0) && !nonzero_at_or_above;
        assign minus = ovf_final;
      end else begin : g_sign
        assign digit = 4'd0;
        assign blank = !neg_reg;
        assign minus = ovf_final || neg_reg;
      end
      seg7_encode #(.ACTIVE_LOW(ACTIVE_LOW)) u_enc (
        .digit (digit),
        .blank (blank),
        .minus (minus),
        .seg   (seg_next[7*gi +: 7])
      );
    end
  endgenerate

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bin_reg      <= '0;
      bcd_reg      <= '0;
      cnt_reg      <= '0;
      neg_reg      <= 1'b0;
      ovf_acc_reg  <= 1'b0;
      overflow_reg <= 1'b0;
      done_reg     <= 1'b0;
      seg_reg      <= SEG_OFF;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        bin_reg     <= value_mag[WIDTH-1:0];
        neg_reg     <= value_neg;
        bcd_reg     <= '0;
        cnt_reg     <= '0;
        ovf_acc_reg <= value_mag[WIDTH];
      end
      if (shift_en) begin
        bcd_reg     <= {bcd_adj[BCD_W-2:0], bin_reg[WIDTH-1]};
        bin_reg     <= {bin_reg[WIDTH-2:0], 1'b0};
        ovf_acc_reg <= ovf_acc_reg | bcd_adj[BCD_W-1];
        cnt_reg     <= cnt_reg + 1'b1;
      end
      if (format_en) begin
        seg_reg      <= seg_next;
        overflow_reg <= ovf_final;
        done_reg     <= 1'b1;
      end
    end
  end

  assign bus.busy     = busy_int;
  assign bus.done     = done_reg;
  assign bus.overflow = overflow_reg;
  assign bus.seg      = seg_reg;
endmodule

// File: tb/tb_bcd_display_driver.sv
// Randomised and directed checks of bcd_display_driver against a decimal-arithmetic model.
module tb_bcd_display_driver;
  logic clock;
  logic reset_n;
  int   n_checks = 0;
  int   n_errors = 0;

  localparam logic [6:0] TB_PAT [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                          7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  localparam logic [6:0] TB_MINUS = 7'h40;
  localparam bit INST_SGN [0:2] = '{1'b0, 1'b1, 1'b0};
  localparam bit INST_BLZ [0:2] = '{1'b1, 1'b1, 1'b0};
  localparam bit INST_AL  [0:2] = '{1'b1, 1'b1, 1'b0};

  bcd_display_driver_if #(.WIDTH(32), .DIGITS(4)) bus0 ();
  bcd_display_driver_if #(.WIDTH(32), .DIGITS(4)) bus1 ();
  bcd_display_driver_if #(.WIDTH(32), .DIGITS(4)) bus2 ();

  bcd_display_driver #(.WIDTH(32), .DIGITS(4), .SIGNED(1'b0), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b1))
    u_dut0 (.clock(clock), .reset_n(reset_n), .bus(bus0));
  bcd_display_driver #(.WIDTH(32), .DIGITS(4), .SIGNED(1'b1), .BLANK_LZ(1'b1), .ACTIVE_LOW(1'b1))
    u_dut1 (.clock(clock), .reset_n(reset_n), .bus(bus1));
  bcd_display_driver #(.WIDTH(32), .DIGITS(4), .SIGNED(1'b0), .BLANK_LZ(1'b0), .ACTIVE_LOW(1'b0))
    u_dut2 (.clock(clock), .reset_n(reset_n), .bus(bus2));

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected {overflow, seg} from plain decimal arithmetic on the operand.
  function automatic logic [28:0] model(input logic [31:0] v, input int inst);
    longint mag, lim, tmp;
    bit neg, ovf;
    int md, top;
    int d [4];
    logic [6:0] p;
    logic [27:0] s;
    neg = INST_SGN[inst] && v[31];
    mag = neg ? ((longint'(1) << 32) - longint'(v)) : longint'(v);
    md  = INST_SGN[inst] ? 3 : 4;
    lim = 1;
    for (int i = 0; i < md; i++) lim = lim * 10;
    ovf = (mag >= lim);
    tmp = mag;
    for (int i = 0; i < 4; i++) begin
      d[i] = int'(tmp % 10);
      tmp  = tmp / 10;
    end
    top = 0;
    for (int i = 0; i < md; i++) if (d[i] != 0) top = i;
    for (int i = 0; i < 4; i++) begin
      if (ovf)                         p = TB_MINUS;
      else if (i >= md)                p = neg ? TB_MINUS : 7'h00;
      else if (INST_BLZ[inst] && i > top) p = 7'h00;
      else                             p = TB_PAT[d[i]];
      s[7*i +: 7] = INST_AL[inst] ? ~p : p;
    end
    return {ovf, s};
  endfunction

  task automatic drive(input int inst, input logic s, input logic [31:0] v);
    case (inst)
      0: begin bus0.start = s; bus0.value = v; end
      1: begin bus1.start = s; bus1.value = v; end
      default: begin bus2.start = s; bus2.value = v; end
    endcase
  endtask

  function automatic logic get_done(input int inst);
    case (inst)
      0: return bus0.done;
      1: return bus1.done;
      default: return bus2.done;
    endcase
  endfunction

  function automatic logic get_busy(input int inst);
    case (inst)
      0: return bus0.busy;
      1: return bus1.busy;
      default: return bus2.busy;
    endcase
  endfunction

  function automatic logic [28:0] get_result(input int inst);
    case (inst)
      0: return {bus0.overflow, bus0.seg};
      1: return {bus1.overflow, bus1.seg};
      default: return {bus2.overflow, bus2.seg};
    endcase
  endfunction

  logic [28:0] last_res;

  task automatic run_conv(input int inst, input logic [31:0] v, input string tag);
    int lat;
    bit seen;
    logic [28:0] exp;
    @(negedge clock);
    drive(inst, 1'b1, v);
    @(posedge clock);
    #1;
    drive(inst, 1'b0, v);
    check({tag, "_busy"}, 64'(get_busy(inst)), 64'd1);
    lat = 0;
    seen = 0;
    while (!seen && lat < 100) begin
      @(posedge clock);
      #1;
      lat++;
      if (get_done(inst)) seen = 1;
    end
    exp = model(v, inst);
    last_res = get_result(inst);
    check({tag, "_latency"}, 64'(lat), 64'd33);
    check({tag, "_seg"}, 64'(last_res[27:0]), 64'(exp[27:0]));
    check({tag, "_ovf"}, 64'(last_res[28]), 64'(exp[28]));
    check({tag, "_idle"}, 64'(get_busy(inst)), 64'd0);
    @(posedge clock);
    #1;
    check({tag, "_pulse"}, 64'(get_done(inst)), 64'd0);
    $display("conv %-10s inst %0d value %08h seg %07h ovf %0d latency %0d",
             tag, inst, v, last_res[27:0], last_res[28], lat);
  endtask

  initial begin
    int ndone, gap, mode;
    bit seen;
    logic [31:0] v;
    logic [28:0] exp;

    reset_n = 1'b0;
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 32'd0);
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 64'(bus0.busy), 64'd0);
    check("rst_done", 64'(bus0.done), 64'd0);
    check("rst_ovf", 64'(bus0.overflow), 64'd0);
    check("rst_seg_al", 64'(bus0.seg), 64'hFFFFFFF);
    check("rst_seg_ah", 64'(bus2.seg), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    run_conv(0, 32'd1234, "d1234");
    check("d1234_d0", 64'(last_res[6:0]), 64'(7'b0011001));
    run_conv(0, 32'd7, "d7");
    check("d7_d0", 64'(last_res[6:0]), 64'(7'b1111000));
    check("d7_hi", 64'(last_res[27:7]), 64'(21'h1FFFFF));
    run_conv(0, 32'd0, "d0");
    check("d0_d0", 64'(last_res[6:0]), 64'(7'b1000000));
    run_conv(0, 32'd10000, "d10000");
    check("d10000_all", 64'(last_res), 64'({1'b1, {4{7'b0111111}}}));
    run_conv(0, 32'd9999, "d9999");
    check("d9999_ovf", 64'(last_res[28]), 64'd0);

    run_conv(1, 32'hFFFFFFD6, "s_m42");
    check("s_m42_all", 64'(last_res[27:0]),
          64'({7'b0111111, 7'b1111111, 7'b0011001, 7'b0100100}));
    run_conv(1, -32'sd1000, "s_m1000");
    check("s_m1000_ovf", 64'(last_res[28]), 64'd1);
    run_conv(1, 32'h80000000, "s_min");
    run_conv(1, -32'sd999, "s_m999");
    run_conv(1, 32'd999, "s_p999");
    run_conv(1, 32'd0, "s_zero");

    run_conv(2, 32'd5, "ah_5");
    check("ah_5_d0", 64'(last_res[6:0]), 64'(7'b1101101));

    for (int k = 0; k < 45; k++) begin
      mode = $urandom_range(0, 3);
      case (mode)
        0: v = $urandom_range(0, 9);
        1: v = $urandom_range(0, 9999);
        2: v = $urandom_range(990, 10010);
        default: v = $urandom;
      endcase
      if ((k % 3) == 1 && $urandom_range(0, 1) == 1) v = -v;
      run_conv(k % 3, v, "rand");
    end

    // A second start during CONVERT must be dropped, not queued.
    @(negedge clock);
    drive(0, 1'b1, 32'd4321);
    @(posedge clock);
    #1;
    drive(0, 1'b0, 32'd4321);
    repeat (4) @(posedge clock);
    @(negedge clock);
    drive(0, 1'b1, 32'd17);
    @(posedge clock);
    #1;
    drive(0, 1'b0, 32'd17);
    ndone = 0;
    repeat (45) begin
      @(posedge clock);
      #1;
      if (bus0.done) begin
        ndone++;
        last_res = {bus0.overflow, bus0.seg};
      end
    end
    exp = model(32'd4321, 0);
    check("ignore_ndone", 64'(ndone), 64'd1);
    check("ignore_seg", 64'(last_res), 64'(exp));
    $display("conv ignore     inst 0 dones %0d seg %07h", ndone, last_res[27:0]);

    // Continuous start: conversions repeat every WIDTH+2 clocks.
    @(negedge clock);
    drive(2, 1'b1, 32'd86);
    gap = 0;
    seen = 0;
    while (!seen && gap < 200) begin
      @(posedge clock);
      #1;
      gap++;
      if (bus2.done) seen = 1;
    end
    gap = 0;
    seen = 0;
    while (!seen && gap < 200) begin
      @(posedge clock);
      #1;
      gap++;
      if (bus2.done) seen = 1;
    end
    drive(2, 1'b0, 32'd86);
    check("b2b_gap", 64'(gap), 64'd34);
    check("b2b_seg", 64'(bus2.seg), 64'(model(32'd86, 2) & 29'h0FFFFFFF));
    $display("conv back2back  inst 2 gap %0d", gap);
    gap = 0;
    while (bus2.busy && gap < 100) begin
      @(posedge clock);
      #1;
      gap++;
    end

    // Reset mid-conversion aborts without a done pulse.
    @(negedge clock);
    drive(0, 1'b1, 32'd4321);
    @(posedge clock);
    #1;
    drive(0, 1'b0, 32'd4321);
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus0.busy), 64'd0);
    check("abort_seg", 64'(bus0.seg), 64'hFFFFFFF);
    check("abort_ovf", 64'(bus0.overflow), 64'd0);
    ndone = 0;
    repeat (3) begin
      @(posedge clock);
      #1;
      if (bus0.done) ndone++;
    end
    @(negedge clock);
    reset_n = 1'b1;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (bus0.done) ndone++;
    end
    check("abort_ndone", 64'(ndone), 64'd0);
    $display("conv abort      inst 0 dones %0d", ndone);
    run_conv(0, 32'd4321, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
